uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that lets several byte producers share the single UART transmit FSM.
- Accepts requests from up to NREQ sources and grants one at a time.
- Loads the winner's byte into the transmitter, pulses start, then waits for the transmitter's Done.
- Enforces an inter-frame gap counted in baud ticks, and flags a timeout if Done never arrives.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width handed to the transmitter.
- GAP_TICKS, 2, baud ticks of idle line between frames (0 allowed).
- TIMEOUT_TICKS, 16, baud ticks allowed in WAIT_DONE before the frame is abandoned.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-source request level.
- req_data  input  NREQ*DATA_W  per-source byte; source i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot, one-cycle acknowledge; data captured in the same cycle.
- owner  output  $clog2(NREQ)  index of the current/last granted source.
- tick  input  1  baud tick from the transmitter; single-cycle pulse.
- tx_data  output  DATA_W  byte presented to the transmitter.
- tx_start  output  1  one-cycle load/start pulse to the transmitter.
- tx_done  input  1  transmitter Done; treated as a level; a frame completes on its 0->1 edge.
- busy  output  1  high in every state except IDLE.
- err_timeout  output  1  one-cycle pulse when a frame is abandoned.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; gnt=0, tx_start=0, err_timeout=0, busy=0.
  - tx_data=0, owner=0, round-robin pointer=0, counters=0.
  - tx_done edge-detect register=0.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE: when any req bit is set, pick the first set bit at or above the pointer, wrapping modulo NREQ. On that same clock edge:
  - register tx_data <= winner's byte and owner <= winner;
  - set gnt[winner] for exactly one cycle;
  - go to START.
- START: tx_start=1 for one cycle; clear the tick counter; go to WAIT_DONE.
- WAIT_DONE: count ticks.
  - tx_done rising edge -> pointer <= owner+1 (mod NREQ), go to GAP.
  - Else, tick counter reaching TIMEOUT_TICKS -> err_timeout pulse, pointer <= owner+1, go to GAP.
  - If the Done edge and the final timeout tick land in the same cycle, Done wins and there is no error.
- GAP: count GAP_TICKS ticks, then go to IDLE. With GAP_TICKS=0, GAP lasts exactly one cycle.
- Latency: req seen in IDLE -> gnt on the next edge -> tx_start one cycle later.
- Requester rules:
  - Hold req and keep req_data stable until gnt.
  - After gnt, req may drop or stay high to queue the next byte.
  - A source holding req continuously gets at most one frame per round-robin cycle.
- Requests arriving while busy are ignored until IDLE; they are level-sensitive, so no loss.
- Single requester: it is granted every frame, regardless of the pointer.
- tx_data holds its value from capture until the next capture.
- Reset asserted mid-frame: abort immediately, no err_timeout. The transmitter is reset by its own reset.
- All counters are sized to hold max(GAP_TICKS, TIMEOUT_TICKS) without wrap. Counters saturate and never wrap.

Decomposition:
- Shared package (uart_pkg):
  - state encoding localparams (IDLE/START/WAIT_DONE/GAP);
  - default DATA_W;
  - a clog2 helper function.
- Sub-module rr_pick: purely combinational. Takes (req, pointer) and returns a winner index plus a valid flag.
- The FSM, counters and edge detect stay in uart_tx_sched.

Test Plan:
- Single source: req=4'b0001, req_data[7:0]=8'b10110011 -> gnt=0001 for 1 cycle; tx_start 1 cycle later with tx_data=8'hB3; on the Done edge plus 2 ticks, busy falls.
- Round robin: all four sources request continuously with bytes A0,A1,A2,A3 -> grant order 0,1,2,3,0. The pointer advances after each Done, and no source gets two consecutive frames.
- Wrap/pointer: pointer=3, req=4'b0101 -> source 0 granted (wrap). The next frame then grants source 2.
- Timeout: tx_done held at 0 -> err_timeout pulses exactly once, on the 16th tick after tx_start. The state then goes GAP -> IDLE and the next requester is served.
- Reset mid-frame: pull reset low during WAIT_DONE -> all outputs are 0 and state is IDLE immediately (asynchronous), with no err_timeout. After release, the pending req is granted from pointer 0.
- Done/timeout race: tx_done edge in the same cycle as the 16th tick -> no err_timeout; normal completion.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_e        : scheduler FSM states
//   DEFAULT_DATA_W : default byte width handed to the transmitter
//   clog2()        : ceiling log2 usable in constant expressions
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_e;

  localparam int unsigned DEFAULT_DATA_W = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index that has highest priority this round
//   win_o   : first set request at or above ptr_i, wrapping modulo NREQ
//   valid_o : at least one request is set
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   win_o,
  output logic            valid_o
);

  int unsigned idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!valid_o && req_i[IW'(idx)]) begin
        valid_o = 1'b1;
        win_o   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ producers.
//   clk, reset   : system clock, asynchronous active-low reset
//   req/req_data : per-source request level and byte (source i at [i*DATA_W +: DATA_W])
//   gnt, owner   : one-cycle one-hot grant, index of current/last winner
//   tick         : baud tick from the transmitter
//   tx_data/tx_start/tx_done : byte, start pulse and Done level to/from the transmitter
//   busy         : scheduler not in IDLE
//   err_timeout  : one-cycle pulse when a frame is abandoned for lack of Done
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned DATA_W        = DEFAULT_DATA_W,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [clog2(NREQ)-1:0]   owner,
  input  logic                     tick,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int unsigned OW   = clog2(NREQ);
  localparam int unsigned MAXT = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
  localparam int unsigned CW   = (clog2(MAXT + 1) < 1) ? 1 : clog2(MAXT + 1);
  localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0] GAP_CNT = CW'(GAP_TICKS);

  state_e              state_q;
  logic [NREQ-1:0]     gnt_q;
  logic                start_q;
  logic                err_q;
  logic [DATA_W-1:0]   data_q;
  logic [OW-1:0]       owner_q;
  logic [OW-1:0]       ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                done_q;
  logic                done_rise;
  logic [OW-1:0]       ptr_d;
  logic [OW-1:0]       pick_idx;
  logic                pick_valid;
  logic [DATA_W-1:0]   pick_data;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (OW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == OW'(i)) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Tick counter only ever counts up; saturates rather than wrapping.
  assign cnt_d     = (tick && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
  assign done_rise = tx_done & ~done_q;
  assign ptr_d     = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= tx_done;
      gnt_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            data_q  <= pick_data;
            owner_q <= pick_idx;
            gnt_q   <= NREQ'(1) << pick_idx;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Done edge is tested first so it beats a timeout in the same cycle.
          if (done_rise) begin
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else if (cnt_d >= TO_CNT) begin
            err_q   <= 1'b1;
            ptr_q   <= ptr_d;
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_GAP: begin
          // With GAP_TICKS=0 the compare is always true: one cycle in GAP.
          if (cnt_d >= GAP_CNT) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign tx_data     = data_q;
  assign tx_start    = start_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int unsigned idx;
    logic [7:0]  dat;
    bit          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        tick;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t exp_q[$];
  vec_t tbl[12];

  localparam logic [31:0] DB3 = {8'hA3, 8'hA2, 8'hA1, 8'hB3};
  localparam logic [31:0] DA  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  uart_tx_sched #(
    .NREQ          (4),
    .DATA_W        (8),
    .GAP_TICKS     (2),
    .TIMEOUT_TICKS (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .owner       (owner),
    .tick        (tick),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_done     (tx_done),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Scoreboard: each start pulse must carry the byte/owner queued when the request was driven.
  always @(negedge clk) begin
    if (reset === 1'b1 && tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_start", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("sb_tx_data", 32'(tx_data), 32'(e.dat));
        check("sb_owner", 32'(owner), e.idx);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic start_frame(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.idx;
    req = v.req;
    req_data = v.data;
    exp_q.push_back(v);
    cyc();
    check("gnt", 32'(gnt), 32'(oh));
    check("owner", 32'(owner), v.idx);
    check("start_not_yet", 32'(tx_start), 32'd0);
    if (!v.hold) req = '0;
    cyc();
    check("tx_start", 32'(tx_start), 32'd1);
    check("gnt_one_cycle", 32'(gnt), 32'd0);
    check("busy", 32'(busy), 32'd1);
    cyc();
    check("tx_start_one_cycle", 32'(tx_start), 32'd0);
  endtask

  task automatic gap_phase(input logic [7:0] dat);
    tick_cyc();
    check("gap_busy", 32'(busy), 32'd1);
    tick_cyc();
    check("busy_fall", 32'(busy), 32'd0);
    check("tx_data_hold", 32'(tx_data), 32'(dat));
  endtask

  task automatic complete_frame(input logic [7:0] dat);
    tick_cyc();
    cyc();
    tick_cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    check("done_busy", 32'(busy), 32'd1);
    check("done_no_err", 32'(err_timeout), 32'd0);
    gap_phase(dat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset = 1'b0; req = '0; req_data = '0; tick = 1'b0; tx_done = 1'b0;
    tbl[0]  = '{4'b0001, DB3, 0, 8'hB3, 1'b0};
    tbl[1]  = '{4'b0001, DB3, 0, 8'hB3, 1'b1};
    tbl[2]  = '{4'b1111, DA,  1, 8'hA1, 1'b1};
    tbl[3]  = '{4'b1111, DA,  2, 8'hA2, 1'b1};
    tbl[4]  = '{4'b1111, DA,  3, 8'hA3, 1'b1};
    tbl[5]  = '{4'b1111, DA,  0, 8'hA0, 1'b1};
    tbl[6]  = '{4'b1111, DA,  1, 8'hA1, 1'b0};
    tbl[7]  = '{4'b1111, DA,  2, 8'hA2, 1'b0};
    tbl[8]  = '{4'b0101, DA,  0, 8'hA0, 1'b0};
    tbl[9]  = '{4'b0101, DA,  2, 8'hA2, 1'b0};
    tbl[10] = '{4'b1000, DA,  3, 8'hA3, 1'b0};
    tbl[11] = '{4'b0110, DA,  1, 8'hA1, 1'b0};

    #3;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 12; i++) begin
      start_frame(tbl[i]);
      complete_frame(tbl[i].dat);
    end

    // Timeout: no Done, error on the 16th tick, then the next requester is served.
    v = '{4'b1000, DA, 3, 8'hA3, 1'b0};
    start_frame(v);
    for (int k = 1; k <= 16; k++) begin
      tick_cyc();
      check("timeout_err", 32'(err_timeout), (k == 16) ? 32'd1 : 32'd0);
      cyc();
      check("timeout_err_idle", 32'(err_timeout), 32'd0);
    end
    check("timeout_busy", 32'(busy), 32'd1);
    gap_phase(8'hA3);
    v = '{4'b0011, DA, 0, 8'hA0, 1'b0};
    start_frame(v);
    complete_frame(v.dat);

    // Done edge coinciding with the 16th tick.
    v = '{4'b0100, DA, 2, 8'hA2, 1'b0};
    start_frame(v);
    for (int k = 1; k <= 15; k++) begin
      tick_cyc();
      cyc();
    end
    check("race_pre_err", 32'(err_timeout), 32'd0);
    tick = 1'b1;
    tx_done = 1'b1;
    cyc();
    tick = 1'b0;
    tx_done = 1'b0;
    check("race_no_err", 32'(err_timeout), 32'd0);
    check("race_busy", 32'(busy), 32'd1);
    cyc();
    check("race_no_err2", 32'(err_timeout), 32'd0);
    gap_phase(8'hA2);
    v = '{4'b0101, DA, 0, 8'hA0, 1'b0};
    start_frame(v);
    complete_frame(v.dat);
    v = '{4'b0010, DA, 1, 8'hA1, 1'b0};
    start_frame(v);
    complete_frame(v.dat);

    // Reset during WAIT_DONE with the pointer at 2.
    v = '{4'b0100, DA, 2, 8'hA2, 1'b1};
    start_frame(v);
    tick_cyc();
    tick_cyc();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_err", 32'(err_timeout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd0);
    req = 4'b0110;
    cyc();
    check("in_rst_err", 32'(err_timeout), 32'd0);
    reset = 1'b1;
    v = '{4'b0110, DA, 1, 8'hA1, 1'b0};
    start_frame(v);
    complete_frame(v.dat);

    cyc();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
